// File: rtl/sdr_data_phase_pkg.sv
// Shared definitions for the I3C SDR data phase.
// Holds the bus-controller state code that enables this stage, the T-bit
// meanings and the SDR byte width. Nothing here is a port; importers use these
// to size and decode their interfaces.
package sdr_data_phase_pkg;

  // Bus controller state encoding, as driven by the controller on state_i.
  localparam int unsigned StateWidth = 3;
  typedef logic [StateWidth-1:0] bus_state_t;

  localparam bus_state_t BusIdle  = 3'd0;
  localparam bus_state_t BusStart = 3'd1;
  localparam bus_state_t BusAddr  = 3'd2;
  localparam bus_state_t BusAck   = 3'd3;
  localparam bus_state_t BusData  = 3'd4;
  localparam bus_state_t BusStop  = 3'd5;

  // Read T-bit: 1 means the target has more data, 0 ends the transfer.
  localparam logic TbitMore = 1'b1;
  localparam logic TbitEnd  = 1'b0;

  localparam int unsigned SdrByteWidth = 8;
  localparam int unsigned BitCntW      = $clog2(SdrByteWidth + 1);

  // Write T-bit makes the 9 transmitted bits carry odd parity.
  function automatic logic odd_parity_tbit(input logic [SdrByteWidth-1:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/sdr_bit_shifter.sv
// 8-bit MSB-first shift register shared by the SDR read and write paths.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   load_i          load load_data_i and clear the bit counter (wins over shift)
//   load_data_i     byte to load
//   shift_i         shift left by one, serial_i enters at bit 0
//   serial_i        serial input (SDA sample on reads)
//   serial_o        current MSB (next bit to drive on writes)
//   data_o          shift register contents
//   bit_cnt_o       bits shifted since the last load, saturates at 8
//   full_o          all 8 bits shifted
module sdr_bit_shifter
  import sdr_data_phase_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic [SdrByteWidth-1:0] load_data_i,
  input  logic                    shift_i,
  input  logic                    serial_i,
  output logic                    serial_o,
  output logic [SdrByteWidth-1:0] data_o,
  output logic [BitCntW-1:0]      bit_cnt_o,
  output logic                    full_o
);

  logic [SdrByteWidth-1:0] sr_q, sr_d;
  logic [BitCntW-1:0]      cnt_q, cnt_d;
  logic                    full;

  assign full = (cnt_q == BitCntW'(SdrByteWidth));

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_data_i;
      cnt_d = '0;
    end else if (shift_i && !full) begin
      sr_d  = {sr_q[SdrByteWidth-2:0], serial_i};
      cnt_d = cnt_q + BitCntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign serial_o  = sr_q[SdrByteWidth-1];
  assign data_o    = sr_q;
  assign bit_cnt_o = cnt_q;
  assign full_o    = full;

endmodule

// File: rtl/sdr_data_phase.sv
// I3C SDR data phase, run after the address stage sees the target ACK.
// Writes serialise controller bytes MSB first, each followed by an odd-parity
// T-bit. Reads deserialise target bytes; the target's T-bit signals more data
// (1) or end of data (0). Bit timing comes from the SCL generator's strobes.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   state_i                bus controller state; this stage runs in BusData
//   addr_acked_i           target ACKed its address
//   is_read_i              transfer direction, 1 = read
//   scl_rise_i/scl_fall_i  SCL sample / drive strobes (rise wins if both)
//   sda_i                  synchronised SDA
//   sda_o, sda_oe_o        SDA drive value and enable
//   tx_data_i/tx_valid_i/tx_last_i/tx_ready_o   write byte stream
//   rx_data_o/rx_valid_o/rx_last_o              read byte stream
//   rx_trunc_o             read stopped at MaxBytes while target wanted more
//   stall_o                write underflow, SCL generator must pause
//   byte_cnt_o             bytes completed in the current transfer
//   done_o                 1-cycle completion pulse (not on abort)
module sdr_data_phase
  import sdr_data_phase_pkg::*;
#(
  parameter int unsigned MaxBytes = 16,
  parameter int unsigned CntW     = $clog2(MaxBytes + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [StateWidth-1:0]   state_i,
  input  logic                    addr_acked_i,
  input  logic                    is_read_i,
  input  logic                    scl_rise_i,
  input  logic                    scl_fall_i,
  input  logic                    sda_i,
  output logic                    sda_o,
  output logic                    sda_oe_o,
  input  logic [SdrByteWidth-1:0] tx_data_i,
  input  logic                    tx_valid_i,
  input  logic                    tx_last_i,
  output logic                    tx_ready_o,
  output logic [SdrByteWidth-1:0] rx_data_o,
  output logic                    rx_valid_o,
  output logic                    rx_last_o,
  output logic                    rx_trunc_o,
  output logic                    stall_o,
  output logic [CntW-1:0]         byte_cnt_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {StIdle, StWaitTx, StBit, StTbit, StDone} sdr_state_e;

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxBytes);

  sdr_state_e              st_q, st_d;
  logic                    is_read_q, is_read_d;
  logic                    last_q, last_d;
  logic                    tbit_q, tbit_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    sda_q, sda_d;
  logic                    oe_q, oe_d;
  logic [SdrByteWidth-1:0] rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    rx_last_q, rx_last_d;
  logic                    trunc_q, trunc_d;

  logic                    sh_load, sh_shift, sh_serial, sh_full;
  logic [SdrByteWidth-1:0] sh_load_data, sh_data;
  logic [BitCntW-1:0]      sh_cnt;

  logic            in_data, rise, fall;
  logic [CntW-1:0] cnt_inc;

  assign in_data = (state_i == BusData);
  assign rise    = scl_rise_i;
  assign fall    = scl_fall_i & ~scl_rise_i;
  assign cnt_inc = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);

  sdr_bit_shifter u_shifter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (sh_load),
    .load_data_i (sh_load_data),
    .shift_i     (sh_shift),
    .serial_i    (sda_i),
    .serial_o    (sh_serial),
    .data_o      (sh_data),
    .bit_cnt_o   (sh_cnt),
    .full_o      (sh_full)
  );

  always_comb begin
    st_d         = st_q;
    is_read_d    = is_read_q;
    last_d       = last_q;
    tbit_d       = tbit_q;
    cnt_d        = cnt_q;
    sda_d        = sda_q;
    oe_d         = oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_last_d    = 1'b0;
    trunc_d      = trunc_q;
    sh_load      = 1'b0;
    sh_load_data = '0;
    sh_shift     = 1'b0;

    if (st_q != StIdle && !in_data) begin
      // Abort: release the bus, keep the byte count for diagnosis.
      st_d  = StIdle;
      oe_d  = 1'b0;
      sda_d = 1'b1;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (in_data && addr_acked_i) begin
            cnt_d     = '0;
            trunc_d   = 1'b0;
            is_read_d = is_read_i;
            if (is_read_i) begin
              st_d    = StBit;
              oe_d    = 1'b0;
              sh_load = 1'b1;
            end else begin
              st_d = StWaitTx;
            end
          end
        end
        StWaitTx: begin
          if (tx_valid_i) begin
            sh_load      = 1'b1;
            sh_load_data = tx_data_i;
            last_d       = tx_last_i;
            tbit_d       = odd_parity_tbit(tx_data_i);
            st_d         = StBit;
          end
        end
        StBit: begin
          if (is_read_q) begin
            oe_d = 1'b0;
            if (rise) begin
              sh_shift = 1'b1;
              if (sh_cnt == BitCntW'(SdrByteWidth - 1)) st_d = StTbit;
            end
          end else if (fall) begin
            oe_d = 1'b1;
            if (!sh_full) begin
              sda_d    = sh_serial;
              sh_shift = 1'b1;
            end else begin
              sda_d = tbit_q;
              st_d  = StTbit;
            end
          end
        end
        StTbit: begin
          if (rise) begin
            cnt_d = cnt_inc;
            if (is_read_q) begin
              rx_valid_d = 1'b1;
              rx_data_d  = sh_data;
              rx_last_d  = (sda_i == TbitEnd);
              if (sda_i == TbitEnd) begin
                st_d = StDone;
              end else if (cnt_inc == MaxCnt) begin
                trunc_d = 1'b1;
                st_d    = StDone;
              end else begin
                st_d    = StBit;
                sh_load = 1'b1;
              end
            end else if (last_q || cnt_inc == MaxCnt) begin
              st_d = StDone;
            end else begin
              st_d = StWaitTx;
            end
          end
        end
        StDone: begin
          oe_d  = 1'b0;
          sda_d = 1'b1;
          st_d  = StIdle;
        end
        default: st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q       <= StIdle;
      is_read_q  <= 1'b0;
      last_q     <= 1'b0;
      tbit_q     <= 1'b0;
      cnt_q      <= '0;
      sda_q      <= 1'b1;
      oe_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      is_read_q  <= is_read_d;
      last_q     <= last_d;
      tbit_q     <= tbit_d;
      cnt_q      <= cnt_d;
      sda_q      <= sda_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_last_q  <= rx_last_d;
      trunc_q    <= trunc_d;
    end
  end

  // Ready is withheld once the controller leaves BusData so no byte is lost.
  assign tx_ready_o = (st_q == StWaitTx) & in_data;
  assign stall_o    = tx_ready_o & ~tx_valid_i;
  assign done_o     = (st_q == StDone);
  assign sda_o      = sda_q;
  assign sda_oe_o   = oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_last_o  = rx_last_q;
  assign rx_trunc_o = trunc_q;
  assign byte_cnt_o = cnt_q;

endmodule

// File: tb/tb_sdr_data_phase.sv
// Scoreboard bench for sdr_data_phase: expected SDA bits and received bytes are
// queued as stimulus is driven and checked by a negedge monitor.
module tb_sdr_data_phase;
  import sdr_data_phase_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_state_t  state;
  logic        addr_acked, is_read, scl_rise, scl_fall, sda_in;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last;

  logic        sda_o, sda_oe_o, tx_ready_o, rx_valid_o, rx_last_o, rx_trunc_o;
  logic        stall_o, done_o;
  logic [7:0]  rx_data_o;
  logic [4:0]  byte_cnt_o;

  logic        sda2, sda_oe2, tx_ready2, rx_valid2, rx_last2, rx_trunc2, stall2, done2;
  logic [7:0]  rx_data2;
  logic [1:0]  byte_cnt2;

  sdr_data_phase u_dut (
    .clk_i(clk), .rst_ni(rst_n), .state_i(state), .addr_acked_i(addr_acked),
    .is_read_i(is_read), .scl_rise_i(scl_rise), .scl_fall_i(scl_fall), .sda_i(sda_in),
    .sda_o(sda_o), .sda_oe_o(sda_oe_o), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_last_i(tx_last), .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_last_o(rx_last_o), .rx_trunc_o(rx_trunc_o),
    .stall_o(stall_o), .byte_cnt_o(byte_cnt_o), .done_o(done_o)
  );

  sdr_data_phase #(.MaxBytes(2)) u_dut_trunc (
    .clk_i(clk), .rst_ni(rst_n), .state_i(state), .addr_acked_i(addr_acked),
    .is_read_i(is_read), .scl_rise_i(scl_rise), .scl_fall_i(scl_fall), .sda_i(sda_in),
    .sda_o(sda2), .sda_oe_o(sda_oe2), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_last_i(tx_last), .tx_ready_o(tx_ready2), .rx_data_o(rx_data2),
    .rx_valid_o(rx_valid2), .rx_last_o(rx_last2), .rx_trunc_o(rx_trunc2),
    .stall_o(stall2), .byte_cnt_o(byte_cnt2), .done_o(done2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues: SDA bits expected at each write sample point, and
  // {byte, last} expected at each rx_valid_o pulse of each instance.
  logic       wr_q[$];
  logic [8:0] rx_q[$];
  logic [8:0] rx2_q[$];
  logic       mon_wr = 1'b0, mon_rd = 1'b0, mon2 = 1'b0;
  int         done_cnt = 0, done2_cnt = 0, oe_rd_cnt = 0;
  logic       exp_bit;
  logic [8:0] exp_rx, exp_rx2;

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (done2) done2_cnt++;
    if (mon_rd && sda_oe_o) oe_rd_cnt++;
    if (mon_wr && scl_rise) begin
      if (wr_q.size() == 0) check_eq("wr_extra_bit", 32'd1, 32'd0);
      else begin
        exp_bit = wr_q.pop_front();
        check_eq("wr_sda", 32'(sda_o), 32'(exp_bit));
        check_eq("wr_oe", 32'(sda_oe_o), 32'd1);
      end
    end
    if (mon_rd && rx_valid_o) begin
      if (rx_q.size() == 0) check_eq("rx_extra_byte", 32'd1, 32'd0);
      else begin
        exp_rx = rx_q.pop_front();
        check_eq("rx_data", 32'(rx_data_o), 32'(exp_rx[8:1]));
        check_eq("rx_last", 32'(rx_last_o), 32'(exp_rx[0]));
      end
    end
    if (mon2 && rx_valid2) begin
      if (rx2_q.size() == 0) check_eq("rx2_extra_byte", 32'd1, 32'd0);
      else begin
        exp_rx2 = rx2_q.pop_front();
        check_eq("rx2_data", 32'(rx_data2), 32'(exp_rx2[8:1]));
        check_eq("rx2_last", 32'(rx_last2), 32'(exp_rx2[0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scl_cycle();
    scl_fall = 1'b1; tick(); scl_fall = 1'b0; tick();
    scl_rise = 1'b1; tick(); scl_rise = 1'b0; tick();
  endtask

  task automatic target_bit(input logic b);
    scl_fall = 1'b1; tick(); scl_fall = 1'b0; sda_in = b; tick();
    scl_rise = 1'b1; tick(); scl_rise = 1'b0; tick();
  endtask

  task automatic target_byte(input logic [7:0] d, input logic t);
    if (mon_rd) rx_q.push_back({d, ~t});
    if (mon2) rx2_q.push_back({d, ~t});
    for (int i = 7; i >= 0; i--) target_bit(d[i]);
    target_bit(t);
  endtask

  // Offers a byte, waits (bounded) for the handshake, then clocks nbits SCL cycles.
  task automatic put_byte(input logic [7:0] d, input logic last, input int nbits);
    bit got_ready;
    for (int i = 7; i >= 0; i--) wr_q.push_back(d[i]);
    wr_q.push_back(~(^d));
    tx_data = d; tx_last = last; tx_valid = 1'b1;
    got_ready = 1'b0;
    for (int k = 0; k < 50 && !got_ready; k++) begin
      @(negedge clk);
      if (tx_ready_o) got_ready = 1'b1;
    end
    if (!got_ready) check_eq("tx_ready_timeout", 32'd0, 32'd1);
    tick();
    tx_valid = 1'b0; tx_last = 1'b0;
    @(negedge clk);
    check_eq("tx_ready_drop", 32'(tx_ready_o), 32'd0);
    tick();
    for (int i = 0; i < nbits; i++) scl_cycle();
  endtask

  task automatic start_xfer(input logic rd);
    state = BusData; addr_acked = 1'b1; is_read = rd;
    tick();
  endtask

  task automatic end_xfer();
    state = BusIdle; addr_acked = 1'b0;
    tick(); tick();
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_sda"}, 32'(sda_o), 32'd1);
    check_eq({pfx, "_oe"}, 32'(sda_oe_o), 32'd0);
    check_eq({pfx, "_rx_data"}, 32'(rx_data_o), 32'd0);
    check_eq({pfx, "_flags"},
             32'({rx_valid_o, rx_last_o, rx_trunc_o, stall_o, tx_ready_o, done_o}), 32'd0);
    check_eq({pfx, "_byte_cnt"}, 32'(byte_cnt_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  int   d0, d2, stalls, changes;
  logic sda_prev;

  initial begin
    rst_n = 1'b0; state = BusIdle; addr_acked = 1'b0; is_read = 1'b0;
    scl_rise = 1'b0; scl_fall = 1'b0; sda_in = 1'b1;
    tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0;
    #12;
    check_reset("reset");
    rst_n = 1'b1;
    tick(); tick();

    // Single write 0xA5, last: bits 1,0,1,0,0,1,0,1 then T=1.
    mon_wr = 1'b1;
    d0 = done_cnt;
    start_xfer(1'b0);
    put_byte(8'hA5, 1'b1, 9);
    end_xfer();
    check_eq("a5_done", 32'(done_cnt - d0), 32'd1);
    check_eq("a5_byte_cnt", 32'(byte_cnt_o), 32'd1);
    check_eq("a5_bits_left", 32'(wr_q.size()), 32'd0);

    // Two bytes: T=0 for 0x07, T=1 for 0xFF.
    d0 = done_cnt;
    start_xfer(1'b0);
    put_byte(8'h07, 1'b0, 9);
    put_byte(8'hFF, 1'b1, 9);
    end_xfer();
    check_eq("two_done", 32'(done_cnt - d0), 32'd1);
    check_eq("two_byte_cnt", 32'(byte_cnt_o), 32'd2);
    check_eq("two_bits_left", 32'(wr_q.size()), 32'd0);

    // Underflow: 20 idle cycles between bytes must stall with SDA steady.
    d0 = done_cnt;
    start_xfer(1'b0);
    put_byte(8'h5A, 1'b0, 9);
    sda_prev = sda_o; stalls = 0; changes = 0;
    repeat (20) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (sda_o !== sda_prev) changes++;
    end
    check_eq("stall_cycles", 32'(stalls), 32'd20);
    check_eq("stall_sda_changes", 32'(changes), 32'd0);
    tick();
    put_byte(8'hC3, 1'b1, 9);
    end_xfer();
    check_eq("stall_done", 32'(done_cnt - d0), 32'd1);
    check_eq("stall_byte_cnt", 32'(byte_cnt_o), 32'd2);
    check_eq("stall_bits_left", 32'(wr_q.size()), 32'd0);

    // Abort after 4 write bits.
    d0 = done_cnt;
    start_xfer(1'b0);
    put_byte(8'hA5, 1'b0, 4);
    state = BusIdle;
    tick();
    @(negedge clk);
    check_eq("abort_oe", 32'(sda_oe_o), 32'd0);
    check_eq("abort_sda", 32'(sda_o), 32'd1);
    check_eq("abort_ready", 32'(tx_ready_o), 32'd0);
    wr_q.delete();
    mon_wr = 1'b0;
    end_xfer();
    check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("abort_byte_cnt", 32'(byte_cnt_o), 32'd0);

    // Read 0x3C (T=1) then 0x81 (T=0).
    mon_rd = 1'b1; oe_rd_cnt = 0;
    d0 = done_cnt;
    start_xfer(1'b1);
    target_byte(8'h3C, TbitMore);
    target_byte(8'h81, TbitEnd);
    end_xfer();
    check_eq("rd_done", 32'(done_cnt - d0), 32'd1);
    check_eq("rd_oe_cycles", 32'(oe_rd_cnt), 32'd0);
    check_eq("rd_bytes_left", 32'(rx_q.size()), 32'd0);
    check_eq("rd_byte_cnt", 32'(byte_cnt_o), 32'd2);
    check_eq("rd_data_hold", 32'(rx_data_o), 32'h81);

    // Truncation on the MaxBytes=2 instance: target keeps T=1.
    mon2 = 1'b1;
    d2 = done2_cnt;
    start_xfer(1'b1);
    target_byte(8'h11, TbitMore);
    target_byte(8'h22, TbitMore);
    check_eq("trunc_flag", 32'(rx_trunc2), 32'd1);
    check_eq("trunc_done", 32'(done2_cnt - d2), 32'd1);
    check_eq("trunc_byte_cnt", 32'(byte_cnt2), 32'd2);
    check_eq("no_trunc_big", 32'(rx_trunc_o), 32'd0);
    end_xfer();
    check_eq("trunc_hold", 32'(rx_trunc2), 32'd1);
    check_eq("trunc_bytes_left", 32'(rx2_q.size()), 32'd0);
    mon2 = 1'b0;
    rx_q.delete();

    // Asynchronous reset in the middle of a read.
    start_xfer(1'b1);
    target_bit(1'b1); target_bit(1'b0); target_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    #3;
    rst_n = 1'b1;
    mon_rd = 1'b0;
    end_xfer();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
